// File: rtl/phv_xbar_arbiter_pkg.sv
// Shared definitions for the PHV crossbar input arbiter and the stage crossbar.
package phv_xbar_arbiter_pkg;

  localparam int PHV_LEN   = 4*8*64+256;
  localparam int ACT_LEN   = 64;
  localparam int ACT_NUM   = 193;
  localparam int ACT_W     = ACT_LEN*ACT_NUM;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_PAUSED = 2'd2
  } arb_state_t;

  // Preferred port after a grant: the port that lost gets priority next time.
  function automatic logic rr_after_grant(input logic [1:0] grant, input logic ptr);
    logic nxt;
    nxt = ptr;
    if (grant[0]) nxt = 1'b1;
    else if (grant[1]) nxt = 1'b0;
    return nxt;
  endfunction

endpackage

// File: rtl/phv_xbar_arbiter_if.sv
// Request, crossbar-output, control and counter signals of the PHV arbiter.
interface phv_xbar_arbiter_if import phv_xbar_arbiter_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic [PHV_LEN-1:0] req_phv_0;
  logic [PHV_LEN-1:0] req_phv_1;
  logic [ACT_W-1:0]   req_act_0;
  logic [ACT_W-1:0]   req_act_1;
  logic               req_valid_0;
  logic               req_valid_1;
  logic               req_ready_0;
  logic               req_ready_1;
  logic [PHV_LEN-1:0] phv_out;
  logic [ACT_W-1:0]   act_out;
  logic               out_valid;
  logic               out_port;
  logic               out_ready;
  logic               pause;
  logic               pause_ack;
  logic               cnt_clr;
  logic [CNT_W-1:0]   grant_cnt_0;
  logic [CNT_W-1:0]   grant_cnt_1;

  // Arbiter side.
  modport master (
    input  req_phv_0, req_phv_1, req_act_0, req_act_1,
    input  req_valid_0, req_valid_1, out_ready, pause, cnt_clr,
    output req_ready_0, req_ready_1, phv_out, act_out, out_valid,
    output out_port, pause_ack, grant_cnt_0, grant_cnt_1
  );

  // Requester / crossbar / software side.
  modport slave (
    output req_phv_0, req_phv_1, req_act_0, req_act_1,
    output req_valid_0, req_valid_1, out_ready, pause, cnt_clr,
    input  req_ready_0, req_ready_1, phv_out, act_out, out_valid,
    input  out_port, pause_ack, grant_cnt_0, grant_cnt_1
  );

endinterface

// File: rtl/phv_xbar_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant plus the updated priority pointer.
module rr_arb2 import phv_xbar_arbiter_pkg::*; (
  input  logic       valid_0,
  input  logic       valid_1,
  input  logic       rr_ptr,
  input  logic       en,
  output logic [1:0] grant,
  output logic       next_ptr
);

  // Pick the preferred port on contention, otherwise whichever port is valid.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid_0 && valid_1) grant = rr_ptr ? 2'b10 : 2'b01;
      else if (valid_0)       grant = 2'b01;
      else if (valid_1)       grant = 2'b10;
    end
    next_ptr = rr_after_grant(grant, rr_ptr);
  end

endmodule

// File: rtl/phv_xbar_arbiter.sv
// Shares one crossbar input between ingress (port 0) and recirculation (port 1).
module phv_xbar_arbiter import phv_xbar_arbiter_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  phv_xbar_arbiter_if.master bus
);

  arb_state_t state;
  logic       rr_ptr;
  logic       rr_next;
  logic       slot_free;
  logic       legal;
  logic [1:0] grant;
  logic       grant_any;

  // The output slot frees up in the same cycle the crossbar takes the held beat.
  assign slot_free = (state == ST_IDLE) || ((state == ST_BUSY) && bus.out_ready);
  assign legal     = (state != ST_PAUSED) && !bus.pause && slot_free;
  assign grant_any = |grant;

  rr_arb2 u_arb (
    .valid_0  (bus.req_valid_0),
    .valid_1  (bus.req_valid_1),
    .rr_ptr   (rr_ptr),
    .en       (legal),
    .grant    (grant),
    .next_ptr (rr_next)
  );

  assign bus.req_ready_0 = grant[0];
  assign bus.req_ready_1 = grant[1];

  // FSM with the output beat registers; a stalled beat is simply not reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_port  <= 1'b0;
      bus.phv_out   <= '0;
      bus.act_out   <= '0;
      bus.pause_ack <= 1'b0;
    end else begin
      rr_ptr <= rr_next;
      if (grant_any) begin
        bus.phv_out   <= grant[1] ? bus.req_phv_1 : bus.req_phv_0;
        bus.act_out   <= grant[1] ? bus.req_act_1 : bus.req_act_0;
        bus.out_port  <= grant[1];
        bus.out_valid <= 1'b1;
        bus.pause_ack <= 1'b0;
        state         <= ST_BUSY;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.pause) begin
              state         <= ST_PAUSED;
              bus.pause_ack <= 1'b1;
            end
          end
          ST_BUSY: begin
            if (bus.out_ready) begin
              bus.out_valid <= 1'b0;
              state         <= bus.pause ? ST_PAUSED : ST_IDLE;
              bus.pause_ack <= bus.pause;
            end
          end
          ST_PAUSED: begin
            if (!bus.pause) begin
              state         <= ST_IDLE;
              bus.pause_ack <= 1'b0;
            end
          end
          default: begin
            state         <= ST_IDLE;
            bus.out_valid <= 1'b0;
            bus.pause_ack <= 1'b0;
          end
        endcase
      end
    end
  end

  // Per-port accepted-beat counters; a clear wins over a same-cycle grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.grant_cnt_0 <= '0;
      bus.grant_cnt_1 <= '0;
    end else if (bus.cnt_clr) begin
      bus.grant_cnt_0 <= '0;
      bus.grant_cnt_1 <= '0;
    end else begin
      if (grant[0]) bus.grant_cnt_0 <= bus.grant_cnt_0 + CNT_W'(1);
      if (grant[1]) bus.grant_cnt_1 <= bus.grant_cnt_1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_phv_xbar_arbiter.sv
// Directed, table-driven bench for phv_xbar_arbiter.
module tb_phv_xbar_arbiter;
  import phv_xbar_arbiter_pkg::*;

  localparam int TB_CNT_W = 8;
  localparam int NVEC = 27;

  logic clk;
  logic rst;

  phv_xbar_arbiter_if #(.CNT_W(TB_CNT_W)) bus ();

  phv_xbar_arbiter #(.CNT_W(TB_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic v0, v1, ordy, pse, clr;
    logic r0, r1, ov, oport, pack;
  } vec_t;

  vec_t vecs[NVEC];
  int   nChecks = 0;
  int   nErrors = 0;

  logic [PHV_LEN-1:0]  last_phv;
  logic [ACT_W-1:0]    last_act;
  logic [TB_CNT_W-1:0] m_cnt0;
  logic [TB_CNT_W-1:0] m_cnt1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] tag_word(input logic port, input int idx);
    logic [63:0] w;
    w = {8'(idx), 7'd0, port, 16'hA5C3 ^ 16'(idx), 32'(idx*7 + 1) ^ {31'd0, port} ^ 32'hC0DE0000};
    return w;
  endfunction

  function automatic logic [PHV_LEN-1:0] make_phv(input logic port, input int idx);
    return {36{tag_word(port, idx)}};
  endfunction

  function automatic logic [ACT_W-1:0] make_act(input logic port, input int idx);
    return {193{~tag_word(port, idx)}};
  endfunction

  function automatic vec_t mk(input logic v0, v1, ordy, pse, clr, r0, r1, ov, oport, pack);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.ordy = ordy; v.pse = pse; v.clr = clr;
    v.r0 = r0; v.r1 = r1; v.ov = ov; v.oport = oport; v.pack = pack;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkWide(input string name, input logic ok, input logic [63:0] act_lo, input logic [63:0] exp_lo);
    nChecks++;
    if (!ok) begin
      nErrors++;
      $display("[TB] FAIL %s: got low word %0h, expected low word %0h", name, act_lo, exp_lo);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    bus.req_valid_0 = v.v0;
    bus.req_valid_1 = v.v1;
    bus.out_ready   = v.ordy;
    bus.pause       = v.pse;
    bus.cnt_clr     = v.clr;
    bus.req_phv_0   = make_phv(1'b0, idx);
    bus.req_phv_1   = make_phv(1'b1, idx);
    bus.req_act_0   = make_act(1'b0, idx);
    bus.req_act_1   = make_act(1'b1, idx);
  endtask

  initial begin
    //              v0 v1 rdy pse clr | r0 r1 | ov port ack
    vecs[0]  = mk(1, 1, 1, 0, 0,  1, 0,  1, 0, 0);
    vecs[1]  = mk(1, 1, 1, 0, 0,  0, 1,  1, 1, 0);
    vecs[2]  = mk(1, 1, 1, 0, 0,  1, 0,  1, 0, 0);
    vecs[3]  = mk(1, 1, 1, 0, 0,  0, 1,  1, 1, 0);
    vecs[4]  = mk(1, 1, 1, 0, 0,  1, 0,  1, 0, 0);
    vecs[5]  = mk(1, 1, 1, 0, 0,  0, 1,  1, 1, 0);
    vecs[6]  = mk(1, 1, 1, 0, 0,  1, 0,  1, 0, 0);
    vecs[7]  = mk(1, 1, 1, 0, 0,  0, 1,  1, 1, 0);
    vecs[8]  = mk(0, 0, 1, 0, 0,  0, 0,  0, 1, 0);
    vecs[9]  = mk(1, 0, 1, 0, 0,  1, 0,  1, 0, 0);
    vecs[10] = mk(1, 1, 0, 0, 0,  0, 0,  1, 0, 0);
    vecs[11] = mk(1, 1, 0, 0, 0,  0, 0,  1, 0, 0);
    vecs[12] = mk(1, 1, 0, 0, 0,  0, 0,  1, 0, 0);
    vecs[13] = mk(1, 1, 0, 0, 0,  0, 0,  1, 0, 0);
    vecs[14] = mk(1, 1, 0, 0, 0,  0, 0,  1, 0, 0);
    vecs[15] = mk(1, 1, 1, 0, 0,  0, 1,  1, 1, 0);
    vecs[16] = mk(1, 1, 0, 1, 0,  0, 0,  1, 1, 0);
    vecs[17] = mk(1, 1, 0, 1, 0,  0, 0,  1, 1, 0);
    vecs[18] = mk(1, 1, 1, 1, 0,  0, 0,  0, 1, 1);
    vecs[19] = mk(1, 1, 1, 1, 0,  0, 0,  0, 1, 1);
    vecs[20] = mk(1, 1, 1, 0, 0,  0, 0,  0, 1, 0);
    vecs[21] = mk(1, 1, 1, 0, 0,  1, 0,  1, 0, 0);
    vecs[22] = mk(1, 1, 1, 0, 1,  0, 1,  1, 1, 0);
    vecs[23] = mk(0, 1, 1, 0, 0,  0, 1,  1, 1, 0);
    vecs[24] = mk(0, 0, 1, 0, 0,  0, 0,  0, 1, 0);
    vecs[25] = mk(1, 1, 1, 1, 0,  0, 0,  0, 1, 1);
    vecs[26] = mk(0, 0, 1, 0, 0,  0, 0,  0, 1, 0);

    rst = 1'b1;
    bus.req_valid_0 = 1'b0;
    bus.req_valid_1 = 1'b0;
    bus.out_ready   = 1'b0;
    bus.pause       = 1'b0;
    bus.cnt_clr     = 1'b0;
    bus.req_phv_0   = '0;
    bus.req_phv_1   = '0;
    bus.req_act_0   = '0;
    bus.req_act_1   = '0;
    last_phv = '0;
    last_act = '0;
    m_cnt0   = '0;
    m_cnt1   = '0;

    #12;
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset out_port", 64'(bus.out_port), 64'd0);
    checkOutput("reset pause_ack", 64'(bus.pause_ack), 64'd0);
    checkOutput("reset grant_cnt_0", 64'(bus.grant_cnt_0), 64'd0);
    checkOutput("reset grant_cnt_1", 64'(bus.grant_cnt_1), 64'd0);
    checkWide("reset phv_out", bus.phv_out === '0, bus.phv_out[63:0], 64'd0);
    checkWide("reset act_out", bus.act_out === '0, bus.act_out[63:0], 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], i);
      #1;
      checkOutput($sformatf("row%0d req_ready_0", i), 64'(bus.req_ready_0), 64'(vecs[i].r0));
      checkOutput($sformatf("row%0d req_ready_1", i), 64'(bus.req_ready_1), 64'(vecs[i].r1));
      @(posedge clk);
      #1;
      if (vecs[i].r0 || vecs[i].r1) begin
        last_phv = make_phv(vecs[i].r1, i);
        last_act = make_act(vecs[i].r1, i);
      end
      if (vecs[i].clr) begin
        m_cnt0 = '0;
        m_cnt1 = '0;
      end else begin
        m_cnt0 = m_cnt0 + TB_CNT_W'(vecs[i].r0);
        m_cnt1 = m_cnt1 + TB_CNT_W'(vecs[i].r1);
      end
      checkOutput($sformatf("row%0d out_valid", i), 64'(bus.out_valid), 64'(vecs[i].ov));
      checkOutput($sformatf("row%0d out_port", i), 64'(bus.out_port), 64'(vecs[i].oport));
      checkOutput($sformatf("row%0d pause_ack", i), 64'(bus.pause_ack), 64'(vecs[i].pack));
      checkWide($sformatf("row%0d phv_out", i), bus.phv_out === last_phv, bus.phv_out[63:0], last_phv[63:0]);
      checkWide($sformatf("row%0d act_out", i), bus.act_out === last_act, bus.act_out[63:0], last_act[63:0]);
      checkOutput($sformatf("row%0d grant_cnt_0", i), 64'(bus.grant_cnt_0), 64'(m_cnt0));
      checkOutput($sformatf("row%0d grant_cnt_1", i), 64'(bus.grant_cnt_1), 64'(m_cnt1));
    end

    // Counter wrap: clear, then 2^CNT_W back-to-back port 1 grants.
    bus.req_valid_0 = 1'b0;
    bus.req_valid_1 = 1'b0;
    bus.out_ready   = 1'b1;
    bus.pause       = 1'b0;
    bus.cnt_clr     = 1'b1;
    @(posedge clk);
    #1;
    bus.cnt_clr     = 1'b0;
    bus.req_valid_1 = 1'b1;
    for (int k = 0; k < (1 << TB_CNT_W) - 1; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("wrap grant_cnt_1 at max", 64'(bus.grant_cnt_1), 64'((1 << TB_CNT_W) - 1));
    @(posedge clk);
    #1;
    checkOutput("wrap grant_cnt_1 to zero", 64'(bus.grant_cnt_1), 64'd0);
    checkOutput("wrap grant_cnt_0 untouched", 64'(bus.grant_cnt_0), 64'd0);

    // Asynchronous reset while a beat is held; port 0 must win afterwards.
    bus.req_valid_1 = 1'b0;
    bus.req_valid_0 = 1'b1;
    bus.req_phv_0   = make_phv(1'b0, 99);
    bus.req_act_0   = make_act(1'b0, 99);
    @(posedge clk);
    #1;
    bus.req_valid_0 = 1'b0;
    bus.out_ready   = 1'b0;
    checkOutput("pre-reset out_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("async reset grant_cnt_0", 64'(bus.grant_cnt_0), 64'd0);
    checkOutput("async reset grant_cnt_1", 64'(bus.grant_cnt_1), 64'd0);
    checkWide("async reset phv_out", bus.phv_out === '0, bus.phv_out[63:0], 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid_0 = 1'b1;
    bus.req_valid_1 = 1'b1;
    bus.out_ready   = 1'b1;
    #1;
    checkOutput("post-reset req_ready_0", 64'(bus.req_ready_0), 64'd1);
    checkOutput("post-reset req_ready_1", 64'(bus.req_ready_1), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("post-reset out_port", 64'(bus.out_port), 64'd0);
    checkOutput("post-reset out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("post-reset grant_cnt_0", 64'(bus.grant_cnt_0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/phv_xbar_arbiter.md
# phv_xbar_arbiter

Two-requester round-robin scheduler that shares one stage crossbar between the ingress PHV stream (port 0) and the recirculation PHV stream (port 1). Each requester presents a PHV plus its full action word. The block grants one requester per beat and registers the winning PHV/action pair. It then drives the crossbar input under a valid/ready handshake and holds the beat stable while the crossbar back-pressures. It also provides a software pause (drain) control and per-port grant counters.

## Interface
- PHV_LEN, 4*8*64+256: PHV width in bits.
- ACT_LEN, 64: width of one sub-action.
- ACT_NUM, 193: sub-actions per action word; action width is ACT_LEN*ACT_NUM.
- CNT_W, 32: grant counter width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- req_phv_0 / req_phv_1  in  PHV_LEN  PHV from port 0 / port 1.
- req_act_0 / req_act_1  in  ACT_LEN*ACT_NUM  action word paired with that PHV.
- req_valid_0 / req_valid_1  in  1  request valid.
- req_ready_0 / req_ready_1  out  1  grant; the beat is taken when valid&&ready.
- phv_out  out  PHV_LEN  registered PHV to the crossbar.
- act_out  out  ACT_LEN*ACT_NUM  registered action word to the crossbar.
- out_valid  out  1  beat valid (drives crossbar phv_in_valid and action_in_valid).
- out_port  out  1  source port of the current beat.
- out_ready  in  1  crossbar ready.
- pause  in  1  level; while high, no new grants are issued.
- pause_ack  out  1  high when paused and the output is empty.
- cnt_clr  in  1  single-cycle clear of both counters.
- grant_cnt_0 / grant_cnt_1  out  CNT_W  accepted beats per port; wrap modulo 2^CNT_W.

## Operation
FSM states: IDLE, BUSY, PAUSED. Reset state is IDLE.

Grant conditions:
- A grant is legal when the state is not PAUSED, pause=0, and the output slot is free.
- The slot is free when the state is IDLE, or when the state is BUSY with out_ready=1.
- req_ready_x is combinational: req_ready_x = legal && winner==x. At most one ready is high per cycle.

Arbitration:
- rr_ptr (reset 0) names the preferred port.
- If both ports are valid, port rr_ptr wins. If one port is valid, it wins.
- After a grant to port k, rr_ptr becomes !k. rr_ptr does not change when there is no grant.

On a grant:
- phv_out, act_out and out_port load from the winning port.
- out_valid becomes 1, and the state becomes BUSY.

State transitions:
- IDLE to BUSY on a grant.
- IDLE to PAUSED when pause=1.
- BUSY: if out_ready=1 and a grant occurs, stay BUSY with the new beat (back-to-back).
- BUSY: if out_ready=1 and there is no grant, out_valid goes to 0. Next state is PAUSED if pause=1, otherwise IDLE.
- BUSY: if out_ready=0, hold everything, including phv_out and act_out, bit-stable.
- PAUSED to IDLE when pause=0.
- pause asserted while BUSY does not drop the held beat. The beat completes first, and only then does the state enter PAUSED.

pause_ack = (state==PAUSED).

Counters:
- grant_cnt_x increments on each accepted input beat for port x.
- cnt_clr has priority: a grant in the same cycle as the clear is not counted, and the counter reads 0 next cycle.

Reset (async, any time): out_valid=0, phv_out=0, act_out=0, out_port=0, rr_ptr=0, both counters=0, pause_ack=0, state=IDLE. An in-flight beat is discarded.

## Timing
- Latency is 1 cycle from input accept to out_valid.
- Throughput is 1 beat/cycle while out_ready=1.
- All outputs except req_ready_x are registered. req_ready_x depends combinationally on req_valid_*, out_ready, pause, state and rr_ptr.
- The crossbar drops its ready one cycle late after it stalls. This block therefore treats out_ready strictly as the handshake for the current cycle and never relies on ready history.
- A counter wraps from 2^CNT_W-1 to 0 without saturating.

## Structure
- Shared package: the FSM state encodings (IDLE=0, BUSY=1, PAUSED=2, 2-bit) and the default PHV_LEN/ACT_LEN/ACT_NUM constants. The crossbar and this block use the same package.
- One sub-module, rr_arb2: inputs are the two valids, rr_ptr and an enable. Outputs are a one-hot grant and the next rr_ptr.
- Datapath registers, the FSM and the counters live in the top module.

## Test plan
- Single port 0 beat A with out_ready=1 -> req_ready_0=1 in the same cycle. Next cycle out_valid=1, phv_out=A, out_port=0. grant_cnt_0=1.
- Both ports valid continuously with out_ready=1 -> grants alternate 0,1,0,1 from reset. After 8 cycles both counters=4.
- Beat B in BUSY, out_ready=0 for 5 cycles -> phv_out and act_out are held equal to B, and both req_ready are 0. When out_ready=1, the next grant is issued in that same cycle.
- pause=1 while BUSY with out_ready=0 -> the beat stays until accepted, then the state goes to PAUSED and pause_ack=1, with no grants. After pause=0 -> IDLE, and grants resume with the rr_ptr preserved.
- cnt_clr in the same cycle as a port 1 grant -> grant_cnt_1=0 next cycle. Separately, preload near wrap with 2^CNT_W grants -> the counter returns to 0.
- rst pulsed mid-stream while BUSY -> out_valid=0 immediately (asynchronously), counters=0, and after release port 0 wins a simultaneous request.
